// File: rtl/apb_master_bridge_if.sv
// Request/response and APB bus bundle for apb_master_bridge.
// Latency: none, wires only.
// Backpressure: req_valid/req_ready on requests; responses are a strobe with no back-pressure.
interface apb_master_bridge_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 32
);
    // requester side
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    // APB side
    logic [ADDR_W-1:0] paddr;
    logic              pwrite;
    logic [DATA_W-1:0] pwdata;
    logic              psel;
    logic              penable;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    // bridge view
    modport master (
        input  req_valid, req_write, req_addr, req_wdata, prdata, pready, pslverr,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, paddr, pwrite, pwdata, psel, penable
    );

    // requester + peripheral view
    modport slave (
        output req_valid, req_write, req_addr, req_wdata, prdata, pready, pslverr,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, paddr, pwrite, pwdata, psel, penable
    );
endinterface

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB initiator: valid/ready request in, APB SETUP/ACCESS out, one-cycle response strobe back.
// Latency: accept at T, SETUP T+1, ACCESS T+2, rsp_valid T+3+W (W = pready-low ACCESS cycles); 3 cycles/transfer back-to-back.
// Backpressure: req_ready only in IDLE; rsp_valid cannot be stalled. Optional APB_MASTER_TIMEOUT_EN aborts ACCESS after TIMEOUT_CYCLES waits.
module apb_master_bridge #(
    parameter int ADDR_W         = 20,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic               clk,
    input  logic               rst,
    apb_master_bridge_if.master bus
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t            state_q, state_d;
    logic              req_ready_q, psel_q, penable_q;
    logic              rsp_valid_q, rsp_err_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic [ADDR_W-1:0] paddr_q;
    logic              pwrite_q;
    logic [DATA_W-1:0] pwdata_q;
    logic              accept, done, abort;
    logic              tmo_hit;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] tmo_cnt_q;

    // Wait-cycle counter: zero outside ACCESS, so it starts clean on every ACCESS entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            tmo_cnt_q <= '0;
        else if (state_q != ACCESS)
            tmo_cnt_q <= '0;
        else if (!bus.pready)
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end

    // The limit-th wait cycle is the one whose closing edge aborts.
    assign tmo_hit = (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    // Timeout disabled: ACCESS waits indefinitely; TIMEOUT_CYCLES has no effect in this build.
    if (TIMEOUT_CYCLES < 1) begin : g_tmo_disabled
    end
    assign tmo_hit = 1'b0;
`endif

    // Next-state decode; pready is only looked at in ACCESS and beats a coincident timeout.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        done    = 1'b0;
        abort   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    accept  = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                if (bus.pready) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end else if (tmo_hit) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and APB/handshake control registers, all derived from the next state so outputs stay registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= (state_d == IDLE);
            psel_q      <= (state_d != IDLE);
            penable_q   <= (state_d == ACCESS);
            rsp_valid_q <= done | abort;
        end
    end

    // Request latch on accept and response capture on completion/abort; both hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            if (accept) begin
                paddr_q  <= bus.req_addr;
                pwrite_q <= bus.req_write;
                pwdata_q <= bus.req_wdata;
            end
            if (done) begin
                rsp_rdata_q <= pwrite_q ? '0 : bus.prdata;
                rsp_err_q   <= bus.pslverr;
            end else if (abort) begin
                rsp_rdata_q <= '0;
                rsp_err_q   <= 1'b1;
            end
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.paddr     = paddr_q;
    assign bus.pwrite    = pwrite_q;
    assign bus.pwdata    = pwdata_q;
    assign bus.psel      = psel_q;
    assign bus.penable   = penable_q;

endmodule
